// File: rtl/cpu6502_pkg.sv
// Shared cpu6502 control-path definitions: flag-update ops, P bit map, branch selects, masks.
// No logic or latency here.
// No flow control here.
package cpu6502_pkg;

    typedef enum logic [2:0] {
        FLG_NONE   = 3'd0,
        FLG_ALU    = 3'd1,
        FLG_BIT    = 3'd2,
        FLG_PULL   = 3'd3,
        FLG_SETCLR = 3'd4
    } flg_op_t;

    localparam int P_N = 7;
    localparam int P_V = 6;
    localparam int P_U = 5;
    localparam int P_B = 4;
    localparam int P_D = 3;
    localparam int P_I = 2;
    localparam int P_Z = 1;
    localparam int P_C = 0;

    typedef enum logic [1:0] {
        BR_N = 2'd0,
        BR_V = 2'd1,
        BR_C = 2'd2,
        BR_Z = 2'd3
    } br_sel_t;

    localparam logic [7:0] MASK_NZ   = 8'h82;
    localparam logic [7:0] MASK_NZC  = 8'h83;
    localparam logic [7:0] MASK_NVZC = 8'hC3;

    // Bits 5/4 have no storage; only N/V/Z/C are driven by the ALU.
    localparam logic [7:0] P_STORED   = 8'hCF;
    localparam logic [7:0] P_ALU_BITS = 8'hC3;

    function automatic logic sc_bit_legal(input logic [2:0] b);
        case (b)
            3'd0, 3'd2, 3'd3, 3'd6: sc_bit_legal = 1'b1;
            default:                sc_bit_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/status_flags_unit.sv
// 6502 processor status register P with push image, branch condition and delayed interrupt mask.
// Latency: flags/irq_mask update on the ce commit edge; push_data/branch_taken combinational from flags.
// Backpressure: none; ce=0 freezes all state and ignores every input.
module status_flags_unit
    import cpu6502_pkg::*;
#(
    parameter logic [7:0] RESET_FLAGS    = 8'h00,
    parameter bit         CLEAR_D_ON_INT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [2:0] op,
    input  logic [7:0] upd_mask,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic [7:0] din,
    input  logic [2:0] sc_bit,
    input  logic       sc_val,
    input  logic       int_entry,
    input  logic       sync,
    input  logic       push_brk,
    input  logic [2:0] cond,
    output logic [7:0] flags,
    output logic [7:0] push_data,
    output logic       branch_taken,
    output logic       irq_mask,
    output logic       dec_mode
);

    localparam logic [7:0] P_RST = RESET_FLAGS & P_STORED;

    logic [7:0] p_q;
    logic       irq_q;
    logic [7:0] alu_vec;
    logic [7:0] alu_sel;
    logic [7:0] p_op;
    logic [7:0] p_nxt;

    assign alu_vec = {alu_n, alu_v, 4'b0000, alu_z, alu_c};
    assign alu_sel = upd_mask & P_ALU_BITS;

    always_comb begin
        p_op = p_q;
        case (flg_op_t'(op))
            FLG_ALU:    p_op = (p_q & ~alu_sel) | (alu_vec & alu_sel);
            FLG_BIT:    p_op = {din[7:6], p_q[5:2], alu_z, p_q[0]};
            FLG_PULL:   p_op = din & P_STORED;
            FLG_SETCLR: begin
                if (sc_bit_legal(sc_bit)) begin
                    p_op[sc_bit] = sc_val;
                end
            end
            default:    p_op = p_q;
        endcase
    end

    // Interrupt entry is applied on top of the op result so it always wins on I.
    always_comb begin
        p_nxt = p_op;
        if (int_entry) begin
            p_nxt[P_I] = 1'b1;
            if (CLEAR_D_ON_INT) begin
                p_nxt[P_D] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q   <= P_RST;
            irq_q <= RESET_FLAGS[P_I];
        end else if (ce) begin
            p_q <= p_nxt & P_STORED;
            // Instruction-boundary sampling of the old I gives CLI/SEI/PLP their one-instruction delay.
            if (int_entry) begin
                irq_q <= 1'b1;
            end else if (sync) begin
                irq_q <= p_q[P_I];
            end
        end
    end

    always_comb begin
        case (br_sel_t'(cond[2:1]))
            BR_N:    branch_taken = (p_q[P_N] == cond[0]);
            BR_V:    branch_taken = (p_q[P_V] == cond[0]);
            BR_C:    branch_taken = (p_q[P_C] == cond[0]);
            default: branch_taken = (p_q[P_Z] == cond[0]);
        endcase
    end

    assign flags     = p_q;
    assign push_data = {p_q[7:6], 1'b1, push_brk, p_q[3:0]};
    assign irq_mask  = irq_q;
    assign dec_mode  = p_q[P_D];

endmodule

// File: tb/tb_status_flags_unit.sv
// Directed plus randomized bench for status_flags_unit against a flag-level reference model.
// Two instances: default parameters and RESET_FLAGS=FF with CLEAR_D_ON_INT=1.
module tb_status_flags_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic [2:0] op;
    logic [7:0] upd_mask;
    logic       alu_n, alu_v, alu_z, alu_c;
    logic [7:0] din;
    logic [2:0] sc_bit;
    logic       sc_val;
    logic       int_entry;
    logic       sync;
    logic       push_brk;
    logic [2:0] cond;

    logic [7:0] flags1, push1, flags2, push2;
    logic       br1, irq1, dec1, br2, irq2, dec2;

    int checks   = 0;
    int failures = 0;

    // Reference state: P as a byte plus the instruction-delayed mask.
    logic [7:0] m1_p, m2_p;
    logic       m1_im, m2_im;

    always #5 clk = ~clk;

    status_flags_unit #(.RESET_FLAGS(8'h00), .CLEAR_D_ON_INT(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .ce(ce), .op(op), .upd_mask(upd_mask),
        .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z), .alu_c(alu_c),
        .din(din), .sc_bit(sc_bit), .sc_val(sc_val), .int_entry(int_entry),
        .sync(sync), .push_brk(push_brk), .cond(cond),
        .flags(flags1), .push_data(push1), .branch_taken(br1),
        .irq_mask(irq1), .dec_mode(dec1)
    );

    status_flags_unit #(.RESET_FLAGS(8'hFF), .CLEAR_D_ON_INT(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .ce(ce), .op(op), .upd_mask(upd_mask),
        .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z), .alu_c(alu_c),
        .din(din), .sc_bit(sc_bit), .sc_val(sc_val), .int_entry(int_entry),
        .sync(sync), .push_brk(push_brk), .cond(cond),
        .flags(flags2), .push_data(push2), .branch_taken(br2),
        .irq_mask(irq2), .dec_mode(dec2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] p, input bit clr_d);
        logic [7:0] r;
        r = p;
        case (op)
            3'd1: begin
                if (upd_mask[7]) r[7] = alu_n;
                if (upd_mask[6]) r[6] = alu_v;
                if (upd_mask[1]) r[1] = alu_z;
                if (upd_mask[0]) r[0] = alu_c;
            end
            3'd2: begin
                r[7] = din[7];
                r[6] = din[6];
                r[1] = alu_z;
            end
            3'd3: r = {din[7:6], 2'b00, din[3:0]};
            3'd4: if (sc_bit == 3'd0 || sc_bit == 3'd2 || sc_bit == 3'd3 || sc_bit == 3'd6)
                      r[sc_bit] = sc_val;
            default: r = p;
        endcase
        if (int_entry) begin
            r[2] = 1'b1;
            if (clr_d) r[3] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic model_branch(input logic [7:0] p, input logic [2:0] c);
        int pos [4] = '{7, 6, 0, 1};
        return p[pos[c[2:1]]] == c[0];
    endfunction

    function automatic logic [7:0] model_push(input logic [7:0] p);
        logic [7:0] r;
        r = p;
        r[5] = 1'b1;
        r[4] = push_brk;
        return r;
    endfunction

    task automatic model_reset();
        m1_p = 8'h00; m1_im = 1'b0;
        m2_p = 8'hCF; m2_im = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_flags1"}, flags1, m1_p);
        chk({tag, "_push1"},  push1,  model_push(m1_p));
        chk({tag, "_br1"},    {7'd0, br1},  {7'd0, model_branch(m1_p, cond)});
        chk({tag, "_irq1"},   {7'd0, irq1}, {7'd0, m1_im});
        chk({tag, "_dec1"},   {7'd0, dec1}, {7'd0, m1_p[3]});
        chk({tag, "_flags2"}, flags2, m2_p);
        chk({tag, "_push2"},  push2,  model_push(m2_p));
        chk({tag, "_br2"},    {7'd0, br2},  {7'd0, model_branch(m2_p, cond)});
        chk({tag, "_irq2"},   {7'd0, irq2}, {7'd0, m2_im});
        chk({tag, "_dec2"},   {7'd0, dec2}, {7'd0, m2_p[3]});
    endtask

    // One commit edge with the inputs currently driven; outputs sampled 1 time unit later.
    task automatic step(input string tag);
        logic [7:0] n1, n2;
        logic       i1, i2;
        n1 = m1_p; n2 = m2_p; i1 = m1_im; i2 = m2_im;
        if (ce) begin
            n1 = model_next(m1_p, 1'b0);
            n2 = model_next(m2_p, 1'b1);
            if (int_entry) begin
                i1 = 1'b1; i2 = 1'b1;
            end else if (sync) begin
                i1 = m1_p[2]; i2 = m2_p[2];
            end
        end
        @(posedge clk);
        #1;
        m1_p = n1; m2_p = n2; m1_im = i1; m2_im = i2;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        ce = 1'b1; op = 3'd0; upd_mask = 8'h00;
        alu_n = 1'b0; alu_v = 1'b0; alu_z = 1'b0; alu_c = 1'b0;
        din = 8'h00; sc_bit = 3'd0; sc_val = 1'b0;
        int_entry = 1'b0; sync = 1'b0; push_brk = 1'b0; cond = 3'd0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #3;
        chk("reset_flags", flags1, 8'h00);
        chk("reset_irq", {7'd0, irq1}, 8'h00);
        check_all("reset");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) step("idle");
        chk("idle_flags", flags1, 8'h00);

        op = 3'd4; sc_bit = 3'd0; sc_val = 1'b0;
        step("clc");
        op = 3'd1; upd_mask = 8'hC3; alu_c = 1'b1;
        step("sbc");
        chk("sbc_flags", flags1, 8'h01);

        idle_inputs();
        op = 3'd4; sc_bit = 3'd2; sc_val = 1'b1; sync = 1'b1;
        step("sei");
        chk("sei_irq_delay", {7'd0, irq1}, 8'h00);
        op = 3'd0;
        step("sei_next");
        chk("sei_irq_set", {7'd0, irq1}, 8'h01);
        op = 3'd4; sc_bit = 3'd2; sc_val = 1'b0;
        step("cli");
        op = 3'd0;
        step("cli_next");
        chk("cli_irq_clear", {7'd0, irq1}, 8'h00);
        sync = 1'b0; int_entry = 1'b1;
        step("int");
        chk("int_flags", flags1, 8'h05);
        chk("int_irq", {7'd0, irq1}, 8'h01);

        idle_inputs();
        op = 3'd3; din = 8'hFF;
        step("pull_ff");
        chk("pull_ff_flags", flags1, 8'hCF);
        op = 3'd0;
        push_brk = 1'b1; #1;
        chk("push_brk1", push1, 8'hFF);
        push_brk = 1'b0; #1;
        chk("push_brk0", push1, 8'hEF);

        op = 3'd2; din = 8'h40; alu_z = 1'b1; cond = 3'b111;
        step("bit");
        chk("bit_flags", flags1, 8'h4F);
        chk("beq", {7'd0, br1}, 8'h01);
        cond = 3'b110; #1;
        chk("bne", {7'd0, br1}, 8'h00);

        idle_inputs();
        op = 3'd3; din = 8'h00; int_entry = 1'b1;
        step("pull_int");
        chk("pull_int_flags", flags1, 8'h04);
        ce = 1'b0; op = 3'd1; upd_mask = 8'hFF; sync = 1'b1;
        alu_n = 1'b1; alu_v = 1'b1; alu_z = 1'b1; alu_c = 1'b1;
        step("ce_off");
        chk("ce_off_flags", flags1, 8'h04);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                #2;
                model_reset();
                check_all("rnd_reset");
                reset = 1'b0;
            end
            ce        = ($urandom_range(0, 7) != 0);
            op        = 3'($urandom_range(0, 4));
            upd_mask  = 8'($urandom);
            alu_n     = 1'($urandom);
            alu_v     = 1'($urandom);
            alu_z     = 1'($urandom);
            alu_c     = 1'($urandom);
            din       = 8'($urandom);
            sc_bit    = 3'($urandom);
            sc_val    = 1'($urandom);
            int_entry = ($urandom_range(0, 9) == 0);
            sync      = 1'($urandom);
            push_brk  = 1'($urandom);
            cond      = 3'($urandom);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
